// File: rtl/wb_master_arb_if.sv
// -----------------------------------------------------------------------------
// wb_master_arb_if
// Bundle of the bus signals around wb_master_arb. It holds the requesting-master
// side (m_*), the shared slave side (s_*) and the arbiter status (grant, busy).
//
// Modports
//   master : the arbiter's view. It takes the master requests and the slave
//            acks/data, and it drives the slave cycle and the master acks.
//   slave  : the environment's view (the masters and slaves around the arbiter).
//
// Signals
//   m_cyc   [N_MASTERS*WB_N] per-master one-hot slave select, master i = [WB_N*i +: WB_N]
//   m_we    [N_MASTERS]      per-master write enable
//   m_addr  [16*N_MASTERS]   per-master address
//   m_wdata [32*N_MASTERS]   per-master write data
//   m_ack   [N_MASTERS]      one-cycle completion pulse to the granted master
//   m_rdata [32]             read data broadcast to all masters
//   s_cyc   [WB_N]           one-hot slave cycle
//   s_we, s_addr, s_wdata    latched request of the granted master
//   s_ack   [WB_N]           per-slave ack
//   s_rdata [32*WB_N]        per-slave read data (zero when not acking)
//   grant   [2]              last or current granted master
//   busy                     high while a transaction is in flight or acking
//   timeout_err              sticky timeout flag (WB_MASTER_ARB_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
interface wb_master_arb_if #(
    parameter int N_MASTERS = 2,
    parameter int WB_N      = 3
);
    logic [N_MASTERS*WB_N-1:0] m_cyc;
    logic [N_MASTERS-1:0]      m_we;
    logic [16*N_MASTERS-1:0]   m_addr;
    logic [32*N_MASTERS-1:0]   m_wdata;
    logic [N_MASTERS-1:0]      m_ack;
    logic [31:0]               m_rdata;
    logic [WB_N-1:0]           s_cyc;
    logic                      s_we;
    logic [15:0]               s_addr;
    logic [31:0]               s_wdata;
    logic [WB_N-1:0]           s_ack;
    logic [32*WB_N-1:0]        s_rdata;
    logic [1:0]                grant;
    logic                      busy;
`ifdef WB_MASTER_ARB_TIMEOUT_EN
    logic                      timeout_err;

    modport master (
        input  m_cyc, m_we, m_addr, m_wdata, s_ack, s_rdata,
        output m_ack, m_rdata, s_cyc, s_we, s_addr, s_wdata, grant, busy, timeout_err
    );

    modport slave (
        output m_cyc, m_we, m_addr, m_wdata, s_ack, s_rdata,
        input  m_ack, m_rdata, s_cyc, s_we, s_addr, s_wdata, grant, busy, timeout_err
    );
`else
    modport master (
        input  m_cyc, m_we, m_addr, m_wdata, s_ack, s_rdata,
        output m_ack, m_rdata, s_cyc, s_we, s_addr, s_wdata, grant, busy
    );

    modport slave (
        output m_cyc, m_we, m_addr, m_wdata, s_ack, s_rdata,
        input  m_ack, m_rdata, s_cyc, s_we, s_addr, s_wdata, grant, busy
    );
`endif
endinterface

// File: rtl/wb_master_arb.sv
// -----------------------------------------------------------------------------
// wb_master_arb
// Round-robin arbiter that lets N_MASTERS Wishbone-style masters share one
// multi-slave bus. Only one transaction is in flight at a time, and every
// output is registered.
//
// Transaction flow: IDLE (arbitrate and latch the request) -> BUSY (wait for an
// ack from the selected slave) -> ACK (one-cycle m_ack pulse) -> IDLE.
// A transaction needs at least 3 cycles when the slave acks in one cycle.
//
// Ports
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : wb_master_arb_if.master (see the interface for the signal list)
//
// Parameters
//   N_MASTERS      : number of requesting masters (1..4)
//   WB_N           : number of slaves (width of the one-hot cyc/ack vectors)
//   TIMEOUT_CYCLES : BUSY cycles without an ack before a forced ack (1..255)
//
// Optional feature, macro WB_MASTER_ARB_TIMEOUT_EN:
//   When the macro is defined, an 8-bit counter ends a BUSY phase that gets no
//   ack after TIMEOUT_CYCLES cycles. The master then receives m_rdata =
//   32'hDEADBEEF and the sticky flag bus.timeout_err is set.
//   When the macro is undefined, BUSY waits for an ack indefinitely.
// -----------------------------------------------------------------------------
module wb_master_arb #(
    parameter int N_MASTERS      = 2,
    parameter int WB_N           = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_master_arb_if.master   bus
);

    if (N_MASTERS < 1 || N_MASTERS > 4) begin : g_bad_n_masters
        $error("wb_master_arb: N_MASTERS must be in 1..4");
    end
    if (WB_N < 1) begin : g_bad_wb_n
        $error("wb_master_arb: WB_N must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("wb_master_arb: TIMEOUT_CYCLES must be in 1..255");
    end

    // After reset, grant points at the last master, so the round-robin search
    // starts at master 0.
    localparam logic [1:0] GRANT_RST = 2'(N_MASTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t               r_state;
    logic [WB_N-1:0]      r_s_cyc;
    logic                 r_s_we;
    logic [15:0]          r_s_addr;
    logic [31:0]          r_s_wdata;
    logic [N_MASTERS-1:0] r_m_ack;
    logic [31:0]          r_m_rdata;
    logic [1:0]           r_grant;
    logic                 r_busy;

    state_t               w_state_nxt;
    logic [WB_N-1:0]      w_s_cyc_nxt;
    logic                 w_s_we_nxt;
    logic [15:0]          w_s_addr_nxt;
    logic [31:0]          w_s_wdata_nxt;
    logic [N_MASTERS-1:0] w_m_ack_nxt;
    logic [31:0]          w_m_rdata_nxt;
    logic [1:0]           w_grant_nxt;

    logic [N_MASTERS-1:0] w_req;
    logic                 w_found;
    logic [1:0]           w_winner;
    logic [WB_N-1:0]      w_win_cyc;
    logic                 w_win_we;
    logic [15:0]          w_win_addr;
    logic [31:0]          w_win_wdata;
    logic [N_MASTERS-1:0] w_ack_vec;
    logic [31:0]          w_rdata_or;
    logic                 w_slave_ack;

`ifdef WB_MASTER_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0]           r_tcnt;
    logic                 r_timeout_err;
    logic [7:0]           w_tcnt_nxt;
    logic [7:0]           w_tcnt_inc;
    logic                 w_timeout_err_nxt;

    assign w_tcnt_inc = r_tcnt + 8'd1;
`endif

    // A master requests when any of its slave-select bits is set.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            w_req[i] = |bus.m_cyc[WB_N*i +: WB_N];
        end
    end

    // Round-robin search. Master (grant+1) mod N has the highest priority and
    // the search wraps. If nobody requests, w_winner keeps the old grant.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_grant;
        for (int k = 1; k <= N_MASTERS; k++) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (!w_found && w_req[i] &&
                    (((int'(r_grant) + k) % N_MASTERS) == i)) begin
                    w_found  = 1'b1;
                    w_winner = 2'(i);
                end
            end
        end
    end

    // Select the request fields of the winning master.
    always_comb begin
        w_win_cyc   = '0;
        w_win_we    = 1'b0;
        w_win_addr  = '0;
        w_win_wdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (w_winner == 2'(i)) begin
                w_win_cyc   = bus.m_cyc[WB_N*i +: WB_N];
                w_win_we    = bus.m_we[i];
                w_win_addr  = bus.m_addr[16*i +: 16];
                w_win_wdata = bus.m_wdata[32*i +: 32];
            end
        end
    end

    // Slaves drive zero when they do not ack, so an OR of all lanes gives the
    // data of the acking slave.
    always_comb begin
        w_rdata_or = '0;
        for (int j = 0; j < WB_N; j++) begin
            w_rdata_or = w_rdata_or | bus.s_rdata[32*j +: 32];
        end
    end

    always_comb begin
        w_ack_vec = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            w_ack_vec[i] = (r_grant == 2'(i));
        end
    end

    // Acks from slaves that are not selected are ignored.
    assign w_slave_ack = |(bus.s_ack & r_s_cyc);

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_s_cyc_nxt   = r_s_cyc;
        w_s_we_nxt    = r_s_we;
        w_s_addr_nxt  = r_s_addr;
        w_s_wdata_nxt = r_s_wdata;
        w_m_ack_nxt   = '0;
        w_m_rdata_nxt = r_m_rdata;
        w_grant_nxt   = r_grant;
`ifdef WB_MASTER_ARB_TIMEOUT_EN
        w_tcnt_nxt        = r_tcnt;
        w_timeout_err_nxt = r_timeout_err;
`endif

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt   = ST_BUSY;
                    w_grant_nxt   = w_winner;
                    w_s_cyc_nxt   = w_win_cyc;
                    w_s_we_nxt    = w_win_we;
                    w_s_addr_nxt  = w_win_addr;
                    w_s_wdata_nxt = w_win_wdata;
`ifdef WB_MASTER_ARB_TIMEOUT_EN
                    w_tcnt_nxt    = '0;
`endif
                end
            end

            // Master inputs are not looked at here. The slave side keeps the
            // latched request until the selected slave acks.
            ST_BUSY: begin
                if (w_slave_ack) begin
                    w_state_nxt   = ST_ACK;
                    w_s_cyc_nxt   = '0;
                    w_m_ack_nxt   = w_ack_vec;
                    w_m_rdata_nxt = w_rdata_or;
                end
`ifdef WB_MASTER_ARB_TIMEOUT_EN
                // A real ack in the same cycle takes priority (branch above).
                else if (w_tcnt_inc == TO_LIMIT) begin
                    w_state_nxt       = ST_ACK;
                    w_s_cyc_nxt       = '0;
                    w_m_ack_nxt       = w_ack_vec;
                    w_m_rdata_nxt     = 32'hDEAD_BEEF;
                    w_timeout_err_nxt = 1'b1;
                    w_tcnt_nxt        = w_tcnt_inc;
                end else begin
                    w_tcnt_nxt = w_tcnt_inc;
                end
`endif
            end

            // No arbitration in this state. The acked master drops its request
            // on the edge that samples m_ack, so it cannot be granted again by
            // mistake.
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_s_cyc_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_s_cyc   <= '0;
            r_s_we    <= 1'b0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_m_ack   <= '0;
            r_m_rdata <= '0;
            r_grant   <= GRANT_RST;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_s_cyc   <= w_s_cyc_nxt;
            r_s_we    <= w_s_we_nxt;
            r_s_addr  <= w_s_addr_nxt;
            r_s_wdata <= w_s_wdata_nxt;
            r_m_ack   <= w_m_ack_nxt;
            r_m_rdata <= w_m_rdata_nxt;
            r_grant   <= w_grant_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

`ifdef WB_MASTER_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_tcnt        <= w_tcnt_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign bus.timeout_err = r_timeout_err;
`endif

    assign bus.s_cyc   = r_s_cyc;
    assign bus.s_we    = r_s_we;
    assign bus.s_addr  = r_s_addr;
    assign bus.s_wdata = r_s_wdata;
    assign bus.m_ack   = r_m_ack;
    assign bus.m_rdata = r_m_rdata;
    assign bus.grant   = r_grant;
    assign bus.busy    = r_busy;

endmodule

// File: tb/tb_wb_master_arb.sv
// -----------------------------------------------------------------------------
// tb_wb_master_arb
// Directed bench for wb_master_arb with two masters and three slaves. The
// bench drives inputs and samples outputs 1 ns after each rising edge. It
// compares every sample against a hand-computed value.
// -----------------------------------------------------------------------------
module tb_wb_master_arb;

    localparam int N_MASTERS      = 2;
    localparam int WB_N           = 3;
    localparam int TIMEOUT_CYCLES = 16;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_err;

    wb_master_arb_if #(.N_MASTERS(N_MASTERS), .WB_N(WB_N)) bus ();

    wb_master_arb #(
        .N_MASTERS      (N_MASTERS),
        .WB_N           (WB_N),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int got_k;
        int g;
        n_cmp = 0;
        n_err = 0;

        rst_n       = 1'b0;
        bus.m_cyc   = '0;
        bus.m_we    = '0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.s_ack   = '0;
        bus.s_rdata = '0;

        // ---------------- reset values ----------------
        tick();
        tick();
        chk("rst_s_cyc",   32'(bus.s_cyc),   32'h0);
        chk("rst_s_we",    32'(bus.s_we),    32'h0);
        chk("rst_s_addr",  32'(bus.s_addr),  32'h0);
        chk("rst_s_wdata", bus.s_wdata,      32'h0);
        chk("rst_m_ack",   32'(bus.m_ack),   32'h0);
        chk("rst_m_rdata", bus.m_rdata,      32'h0);
        chk("rst_grant",   32'(bus.grant),   32'h1);
        chk("rst_busy",    32'(bus.busy),    32'h0);
`ifdef WB_MASTER_ARB_TIMEOUT_EN
        chk("rst_timeout_err", 32'(bus.timeout_err), 32'h0);
`endif
        rst_n = 1'b1;
        tick();

        // ---------------- single read: m0 -> slave 1 ----------------
        bus.m_cyc         = 6'b000_010;
        bus.m_addr[15:0]  = 16'h0010;
        bus.m_we          = 2'b00;
        tick();
        chk("rd_s_cyc",  32'(bus.s_cyc),  32'h2);
        chk("rd_grant",  32'(bus.grant),  32'h0);
        chk("rd_busy",   32'(bus.busy),   32'h1);
        chk("rd_s_addr", 32'(bus.s_addr), 32'h0010);
        chk("rd_s_we",   32'(bus.s_we),   32'h0);
        tick();
        chk("rd_no_ack_early", 32'(bus.m_ack), 32'h0);
        tick();
        bus.s_ack           = 3'b010;
        bus.s_rdata[63:32]  = 32'h1234_5678;
        tick();
        chk("rd_m_ack",   32'(bus.m_ack), 32'h1);
        chk("rd_m_rdata", bus.m_rdata,    32'h1234_5678);
        chk("rd_s_cyc_drop", 32'(bus.s_cyc), 32'h0);
        bus.m_cyc   = '0;
        bus.s_ack   = '0;
        bus.s_rdata = '0;
        tick();
        chk("rd_ack_pulse_end", 32'(bus.m_ack), 32'h0);
        chk("rd_busy_end",      32'(bus.busy),  32'h0);
        chk("rd_rdata_hold",    bus.m_rdata,    32'h1234_5678);

        // ---------------- simultaneous writes, round robin ----------------
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.m_cyc   = {3'b001, 3'b001};
        bus.m_we    = 2'b11;
        bus.m_addr  = {16'h0002, 16'h0001};
        bus.m_wdata = {32'hBBBB_0000, 32'hAAAA_0000};
        for (int t = 0; t < 4; t++) begin
            g = t % 2;
            tick();
            chk($sformatf("rr%0d_grant", t),   32'(bus.grant),  32'(g));
            chk($sformatf("rr%0d_s_addr", t),  32'(bus.s_addr), (g == 1) ? 32'h2 : 32'h1);
            chk($sformatf("rr%0d_s_wdata", t), bus.s_wdata,     (g == 1) ? 32'hBBBB_0000 : 32'hAAAA_0000);
            chk($sformatf("rr%0d_s_we", t),    32'(bus.s_we),   32'h1);
            bus.s_ack = 3'b001;
            tick();
            chk($sformatf("rr%0d_m_ack", t),   32'(bus.m_ack),  (g == 1) ? 32'h2 : 32'h1);
            chk($sformatf("rr%0d_m_rdata", t), bus.m_rdata,     32'h0);
            bus.s_ack = '0;
            tick();
            chk($sformatf("rr%0d_ack_end", t), 32'(bus.m_ack),  32'h0);
        end
        bus.m_cyc = '0;
        bus.m_we  = '0;

        // ---------------- request change during BUSY ----------------
        bus.m_cyc        = 6'b000_001;
        bus.m_addr[15:0] = 16'h0004;
        tick();
        chk("chg_grant",  32'(bus.grant),  32'h0);
        chk("chg_s_addr", 32'(bus.s_addr), 32'h0004);
        bus.m_addr[15:0] = 16'h0008;
        tick();
        chk("chg_s_addr_hold", 32'(bus.s_addr), 32'h0004);
        chk("chg_s_cyc_hold",  32'(bus.s_cyc),  32'h1);
        bus.s_ack = 3'b001;
        tick();
        chk("chg_m_ack",       32'(bus.m_ack),  32'h1);
        chk("chg_s_addr_done", 32'(bus.s_addr), 32'h0004);
        bus.m_cyc = '0;
        bus.s_ack = '0;
        tick();

        // ---------------- stray ack from an unselected slave ----------------
        bus.m_cyc          = 6'b001_000;
        bus.m_addr[31:16]  = 16'h0030;
        tick();
        chk("stray_grant", 32'(bus.grant), 32'h1);
        chk("stray_s_cyc", 32'(bus.s_cyc), 32'h1);
        bus.s_ack           = 3'b100;
        bus.s_rdata[95:64]  = 32'h55AA_55AA;
        tick();
        chk("stray_no_ack", 32'(bus.m_ack), 32'h0);
        chk("stray_s_cyc_hold", 32'(bus.s_cyc), 32'h1);
        chk("stray_busy", 32'(bus.busy), 32'h1);
        bus.s_ack   = 3'b001;
        bus.s_rdata = {32'h0, 32'h0, 32'hCAFE_F00D};
        tick();
        chk("stray_real_ack", 32'(bus.m_ack), 32'h2);
        chk("stray_rdata",    bus.m_rdata,    32'hCAFE_F00D);
        bus.m_cyc   = '0;
        bus.s_ack   = '0;
        bus.s_rdata = '0;
        tick();

        // ---------------- async reset mid-transfer ----------------
        bus.m_cyc  = {3'b001, 3'b010};
        bus.m_addr = {16'h0050, 16'h0040};
        tick();
        chk("rst_mid_grant", 32'(bus.grant), 32'h0);
        chk("rst_mid_s_cyc", 32'(bus.s_cyc), 32'h2);
        #2;
        rst_n     = 1'b0;
        bus.s_ack = 3'b010;
        #1;
        chk("rst_mid_s_cyc_drop", 32'(bus.s_cyc), 32'h0);
        chk("rst_mid_busy",       32'(bus.busy),  32'h0);
        chk("rst_mid_grant_rst",  32'(bus.grant), 32'h1);
        tick();
        chk("rst_mid_no_ack", 32'(bus.m_ack), 32'h0);
        bus.s_ack = '0;
        rst_n     = 1'b1;
        tick();
        chk("rst_rearb_grant",  32'(bus.grant),  32'h0);
        chk("rst_rearb_s_cyc",  32'(bus.s_cyc),  32'h2);
        chk("rst_rearb_s_addr", 32'(bus.s_addr), 32'h0040);
        bus.s_ack          = 3'b010;
        bus.s_rdata[63:32] = 32'h0BAD_F00D;
        tick();
        chk("rst_rearb_m_ack", 32'(bus.m_ack), 32'h1);
        chk("rst_rearb_rdata", bus.m_rdata,    32'h0BAD_F00D);
        bus.m_cyc   = '0;
        bus.s_ack   = '0;
        bus.s_rdata = '0;
        tick();

`ifdef WB_MASTER_ARB_TIMEOUT_EN
        // ---------------- timeout: slave never acks ----------------
        bus.m_cyc        = 6'b000_100;
        bus.m_addr[15:0] = 16'h0060;
        tick();
        chk("to_s_cyc", 32'(bus.s_cyc), 32'h4);
        got_k = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.m_ack != '0) begin
                got_k = k;
                break;
            end
        end
        chk("to_busy_cycles", 32'(got_k),        32'(TIMEOUT_CYCLES));
        chk("to_m_ack",       32'(bus.m_ack),    32'h1);
        chk("to_m_rdata",     bus.m_rdata,       32'hDEAD_BEEF);
        chk("to_err_set",     32'(bus.timeout_err), 32'h1);
        chk("to_s_cyc_drop",  32'(bus.s_cyc),    32'h0);
        bus.m_cyc = '0;
        tick();
        chk("to_err_sticky", 32'(bus.timeout_err), 32'h1);
        bus.m_cyc = 6'b000_100;
        tick();
        bus.s_ack          = 3'b100;
        bus.s_rdata[95:64] = 32'h600D_D00D;
        tick();
        chk("to_next_m_ack", 32'(bus.m_ack), 32'h1);
        chk("to_next_rdata", bus.m_rdata,    32'h600D_D00D);
        chk("to_err_still",  32'(bus.timeout_err), 32'h1);
        bus.m_cyc   = '0;
        bus.s_ack   = '0;
        bus.s_rdata = '0;
        tick();
`else
        got_k = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
